// File: rtl/vga_timing_pkg.sv
// Shared timing defaults, receiver state encoding and colour packing for the
// VGA receive path.
package vga_timing_pkg;

  localparam int H_ACTIVE_DEF    = 640;
  localparam int H_TOTAL_DEF     = 800;
  localparam int V_ACTIVE_DEF    = 480;
  localparam int V_TOTAL_DEF     = 525;
  localparam int LOCK_FRAMES_DEF = 2;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } rx_state_t;

  // RRRGGGBB from the top bits of each 8-bit channel.
  function automatic logic [7:0] pack_rgb332(input logic [7:0] r,
                                             input logic [7:0] g,
                                             input logic [7:0] b);
    return {r[7:5], g[7:5], b[7:6]};
  endfunction

endpackage

// File: rtl/vga_rx_sync_edge.sv
// Registers one sync pin twice and flags its falling edge. Both stages reset
// high (the idle level of an active-low sync) so leaving reset never looks
// like an edge.
module vga_rx_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic sig_i,
  output logic fall_o
);

  logic s1_q;
  logic dly_q;

  // Input register followed by a one-cycle delay for edge detection.
  // NOTE: non-blocking assignments so dly_q captures the previous s1_q, not the new one.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q  <= 1'b1;
      dly_q <= 1'b1;
    end else begin
      s1_q  <= sig_i;
      dly_q <= s1_q;
    end
  end

  assign fall_o = ~s1_q & dly_q;

endmodule

// File: rtl/vga_rx_decoder.sv
// VGA sink: recovers pixel coordinates and RRRGGGBB colour from the pins,
// checks line/frame timing, locks after LOCK_FRAMES clean frames and reports
// violations. Pin-to-pix_* latency is two clocks.
module vga_rx_decoder
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE    = H_ACTIVE_DEF,
  parameter int H_TOTAL     = H_TOTAL_DEF,
  parameter int V_ACTIVE    = V_ACTIVE_DEF,
  parameter int V_TOTAL     = V_TOTAL_DEF,
  parameter int LOCK_FRAMES = LOCK_FRAMES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        blank_n,
  input  logic [7:0]  red,
  input  logic [7:0]  green,
  input  logic [7:0]  blue,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [7:0]  pix_color,
  output logic        frame_start,
  output logic        locked,
  output logic        timing_err,
  output logic [15:0] frame_count,
  output logic [7:0]  err_count
);

  localparam logic [9:0] CNT_MAX     = '1;
  localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_ACT       = 10'(H_ACTIVE);
  localparam logic [9:0] V_TOT       = 10'(V_TOTAL);
  localparam logic [9:0] V_ACT       = 10'(V_ACTIVE);
  localparam logic [3:0] GOOD_TARGET = 4'(LOCK_FRAMES);

  // Input stage
  logic       hs_fall, vs_fall;
  logic       blank_s1_q;
  logic [7:0] color_s1_q;

  // Line/frame counters
  logic [9:0] hcnt_q, hcnt_d;
  logic [9:0] acnt_q, acnt_d;
  logic [9:0] vcnt_q, vcnt_d;
  logic [9:0] vact_q, vact_d;
  logic [9:0] acnt_base, vcnt_tot, vact_tot;
  logic       line_active, line_bad, frame_bad, viol;

  // FSM and status
  rx_state_t  state_q, state_d;
  logic [3:0] good_q, good_d;
  logic       frame_start_d, timing_err_d;
  logic       locked_q, frame_start_q, timing_err_q;
  logic [15:0] frame_count_q;
  logic [7:0]  err_count_q;

  // Pixel outputs
  logic       pix_valid_q, pix_valid_d;
  logic [9:0] pix_x_q, pix_y_q;
  logic [7:0] pix_color_q;

  vga_rx_sync_edge u_hs_edge (
    .clk    (clk),
    .reset  (reset),
    .sig_i  (hsync),
    .fall_o (hs_fall)
  );

  vga_rx_sync_edge u_vs_edge (
    .clk    (clk),
    .reset  (reset),
    .sig_i  (vsync),
    .fall_o (vs_fall)
  );

  // Register blank and the packed colour alongside the sync stages.
  always_ff @(posedge clk) begin
    if (reset) begin
      blank_s1_q <= 1'b0;
      color_s1_q <= '0;
    end else begin
      blank_s1_q <= blank_n;
      color_s1_q <= pack_rgb332(red, green, blue);
    end
  end

  // Counter next-state and timing checks. A line closing on the same cycle
  // as vs_fall is folded into the frame totals before they are judged.
  always_comb begin
    // NOTE: every variable gets a value before any conditional update, so no latch is inferred.
    vcnt_tot    = vcnt_q;
    vact_tot    = vact_q;
    acnt_base   = hs_fall ? '0 : acnt_q;
    line_active = (acnt_q != '0);
    line_bad    = hs_fall && ((hcnt_q != H_LAST) || (line_active && (acnt_q != H_ACT)));
    if (hs_fall && (vcnt_q != CNT_MAX)) begin
      vcnt_tot = vcnt_q + 10'd1;
    end
    if (hs_fall && line_active && (vact_q != CNT_MAX)) begin
      vact_tot = vact_q + 10'd1;
    end
    frame_bad = vs_fall && ((vcnt_tot != V_TOT) || (vact_tot != V_ACT));
    viol      = line_bad || frame_bad;
    hcnt_d    = hs_fall ? '0 : ((hcnt_q == CNT_MAX) ? hcnt_q : hcnt_q + 10'd1);
    acnt_d    = (blank_s1_q && (acnt_base != CNT_MAX)) ? acnt_base + 10'd1 : acnt_base;
    vcnt_d    = vs_fall ? '0 : vcnt_tot;
    vact_d    = vs_fall ? '0 : vact_tot;
  end

  // Lock FSM: violations are silent while acquiring, reported once locked.
  always_comb begin
    state_d       = state_q;
    good_d        = good_q;
    frame_start_d = 1'b0;
    timing_err_d  = 1'b0;
    unique case (state_q)
      HUNT: begin
        if (vs_fall) begin
          state_d = ACQUIRE;
          good_d  = '0;
        end
      end
      ACQUIRE: begin
        if (viol) begin
          state_d = HUNT;
        end else if (vs_fall) begin
          good_d = good_q + 4'd1;
          if (good_q + 4'd1 >= GOOD_TARGET) begin
            state_d = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (viol) begin
          state_d      = HUNT;
          timing_err_d = 1'b1;
        end else if (vs_fall) begin
          frame_start_d = 1'b1;
        end
      end
      default: state_d = HUNT;
    endcase
  end

  assign pix_valid_d = (state_q == LOCKED) && blank_s1_q;

  // Counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      hcnt_q <= '0;
      acnt_q <= '0;
      vcnt_q <= '0;
      vact_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      acnt_q <= acnt_d;
      vcnt_q <= vcnt_d;
      vact_q <= vact_d;
    end
  end

  // FSM state and status outputs; err_count saturates, frame_count wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= HUNT;
      good_q        <= '0;
      locked_q      <= 1'b0;
      frame_start_q <= 1'b0;
      timing_err_q  <= 1'b0;
      frame_count_q <= '0;
      err_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      good_q        <= good_d;
      locked_q      <= (state_d == LOCKED);
      frame_start_q <= frame_start_d;
      timing_err_q  <= timing_err_d;
      if (frame_start_d) begin
        frame_count_q <= frame_count_q + 16'd1;
      end
      if (timing_err_d && (err_count_q != 8'hFF)) begin
        err_count_q <= err_count_q + 8'd1;
      end
    end
  end

  // Pixel outputs; coordinates and colour hold while no pixel is valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      pix_valid_q <= 1'b0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      pix_color_q <= '0;
    end else begin
      pix_valid_q <= pix_valid_d;
      if (pix_valid_d) begin
        pix_x_q     <= acnt_base;
        pix_y_q     <= vact_d;
        pix_color_q <= color_s1_q;
      end
    end
  end

  assign pix_valid   = pix_valid_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign pix_color   = pix_color_q;
  assign frame_start = frame_start_q;
  assign locked      = locked_q;
  assign timing_err  = timing_err_q;
  assign frame_count = frame_count_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_vga_rx_decoder.sv
// Directed bench for vga_rx_decoder using a scaled-down raster (32x24 active,
// 48x30 total) so each scenario spans a few thousand clocks.
module tb_vga_rx_decoder;

  localparam int TH_ACT     = 32;
  localparam int TH_TOT     = 48;
  localparam int HS_LEN     = 4;
  localparam int H_START    = 10;
  localparam int TV_ACT     = 24;
  localparam int TV_TOT     = 30;
  localparam int VS_LEN     = 2;
  localparam int V_START    = 4;
  localparam int FRAME_CLKS = 1440;
  localparam int PIX_FRAME  = 768;

  logic        clk = 1'b0;
  logic        reset, hsync, vsync, blank_n;
  logic [7:0]  red, green, blue;
  logic        pix_valid, frame_start, locked, timing_err;
  logic [9:0]  pix_x, pix_y;
  logic [7:0]  pix_color, err_count;
  logic [15:0] frame_count;

  always #20 clk = ~clk;

  vga_rx_decoder #(
    .H_ACTIVE    (TH_ACT),
    .H_TOTAL     (TH_TOT),
    .V_ACTIVE    (TV_ACT),
    .V_TOTAL     (TV_TOT),
    .LOCK_FRAMES (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .hsync       (hsync),
    .vsync       (vsync),
    .blank_n     (blank_n),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .pix_valid   (pix_valid),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .pix_color   (pix_color),
    .frame_start (frame_start),
    .locked      (locked),
    .timing_err  (timing_err),
    .frame_count (frame_count),
    .err_count   (err_count)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    int         x;
    int         y;
    logic [7:0] col;
  } probe_t;

  probe_t probe_q[$];
  bit     probe_en    = 1'b0;
  int     probes_done = 0;

  int frame_pin_cyc = 0;
  int close_cyc     = 0;
  int rst_cyc       = -10;

  // Monitor state, written only by the monitor process.
  int   pv_cnt = 0, fs_cnt = 0, te_cnt = 0, pv_since_te = 0;
  int   fs_prev = 0, fs_gap = 0;
  int   lock_rise_cyc = -1, te_rise_cyc = -1;
  logic locked_prev = 1'b0, te_prev = 1'b0;
  logic snap_locked, snap_pv;
  logic [15:0] snap_fc;
  logic [7:0]  snap_ec;

  always @(negedge clk) begin
    probe_t p;
    if (locked === 1'b1 && locked_prev !== 1'b1) lock_rise_cyc = cyc;
    locked_prev = locked;
    if (pix_valid === 1'b1) pv_cnt++;
    if (frame_start === 1'b1) begin
      fs_cnt++;
      fs_gap  = cyc - fs_prev;
      fs_prev = cyc;
    end
    if (timing_err === 1'b1) begin
      te_cnt++;
      if (te_prev !== 1'b1) te_rise_cyc = cyc;
      pv_since_te = 0;
    end else if (pix_valid === 1'b1) begin
      pv_since_te++;
    end
    te_prev = timing_err;
    if (cyc == rst_cyc + 1) begin
      snap_locked = locked;
      snap_pv     = pix_valid;
      snap_fc     = frame_count;
      snap_ec     = err_count;
    end
    if (probe_q.size() != 0 && cyc == probe_q[0].cyc) begin
      p = probe_q.pop_front();
      check($sformatf("probe(%0d,%0d) valid", p.x, p.y), {31'd0, pix_valid}, 32'd1);
      check($sformatf("probe(%0d,%0d) x", p.x, p.y), {22'd0, pix_x}, p.x);
      check($sformatf("probe(%0d,%0d) y", p.x, p.y), {22'd0, pix_y}, p.y);
      check($sformatf("probe(%0d,%0d) color", p.x, p.y), {24'd0, pix_color}, {24'd0, p.col});
      probes_done++;
    end
  end

  // One frame of pins. bad_line gets 'extra' clocks of period and 'trim'
  // fewer active clocks; rst_line pulses reset for its first clock.
  task automatic drive_frame(input int n_lines, input int bad_line, input int extra,
                             input int trim, input int rst_line);
    for (int l = 0; l < n_lines; l++) begin
      int len, alen;
      len  = TH_TOT + ((l == bad_line) ? extra : 0);
      alen = TH_ACT - ((l == bad_line) ? trim : 0);
      for (int c = 0; c < len; c++) begin
        bit     act;
        int     x, y;
        probe_t p;
        @(negedge clk);
        if (l == 0 && c == 0) frame_pin_cyc = cyc;
        if (l == bad_line + 1 && c == 0) close_cyc = cyc;
        reset = (l == rst_line && c == 0);
        if (l == rst_line && c == 0) rst_cyc = cyc;
        hsync   = (c >= HS_LEN);
        vsync   = (l >= VS_LEN);
        act     = (l >= V_START) && (l < V_START + TV_ACT) && (c >= H_START) && (c < H_START + alen);
        x       = c - H_START;
        y       = l - V_START;
        blank_n = act;
        if (act) begin
          if (x == 10 && y == 20) begin
            red = 8'hFF; green = 8'h00; blue = 8'hC0;
          end else begin
            red = 8'(x * 8); green = 8'(y * 8); blue = 8'h5A;
          end
          if (probe_en) begin
            p.cyc = cyc + 2;
            p.x   = x;
            p.y   = y;
            p.col = 8'h00;
            if (x == 10 && y == 20) p.col = 8'hE3;
            if (x == 0 && y == 0) p.col = 8'h01;
            if (x == 31 && y == 23) p.col = 8'hF5;
            if (p.col != 8'h00) probe_q.push_back(p);
          end
        end else begin
          red = 8'h00; green = 8'h00; blue = 8'h00;
        end
      end
    end
  endtask

  task automatic clean_frame();
    drive_frame(TV_TOT, -5, 0, 0, -1);
  endtask

  initial begin
    int pv0, te0, fc0;
    reset = 1'b1; hsync = 1'b1; vsync = 1'b1; blank_n = 1'b0;
    red = 8'h00; green = 8'h00; blue = 8'h00;
    repeat (3) @(negedge clk);
    check("rst locked", {31'd0, locked}, 32'd0);
    check("rst pix_valid", {31'd0, pix_valid}, 32'd0);
    check("rst frame_start", {31'd0, frame_start}, 32'd0);
    check("rst timing_err", {31'd0, timing_err}, 32'd0);
    check("rst frame_count", {16'd0, frame_count}, 32'd0);
    check("rst err_count", {24'd0, err_count}, 32'd0);
    check("rst pix_x", {22'd0, pix_x}, 32'd0);
    check("rst pix_color", {24'd0, pix_color}, 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Initial lock: vs_fall at start of A -> ACQUIRE, end of B -> LOCKED.
    clean_frame();
    clean_frame();
    check("lock before 2 frames", {31'd0, locked}, 32'd0);
    pv0 = pv_cnt;
    probe_en = 1'b1;
    clean_frame();
    probe_en = 1'b0;
    check("lock rise cycle", lock_rise_cyc, frame_pin_cyc + 2);
    check("locked after 2 frames", {31'd0, locked}, 32'd1);
    check("pix_valid per frame", pv_cnt - pv0, PIX_FRAME);
    check("frame_start suppressed at lock", fs_cnt, 32'd0);
    check("frame_count at lock", {16'd0, frame_count}, 32'd0);
    check("pix_x hold", {22'd0, pix_x}, 32'd31);
    check("pix_y hold", {22'd0, pix_y}, 32'd23);
    check("probes seen", probes_done, 32'd3);
    clean_frame();
    check("frame_count 1", {16'd0, frame_count}, 32'd1);
    check("frame_start count 1", fs_cnt, 32'd1);
    pv0 = pv_cnt;
    clean_frame();
    check("frame_count 2", {16'd0, frame_count}, 32'd2);
    check("frame_start period", fs_gap, FRAME_CLKS);
    check("pix_valid per frame 2", pv_cnt - pv0, PIX_FRAME);

    // One line one clock too long while locked.
    te0 = te_cnt;
    drive_frame(TV_TOT, 10, 1, 0, -1);
    check("long line err pulses", te_cnt - te0, 32'd1);
    check("long line err cycle", te_rise_cyc, close_cyc + 2);
    check("long line locked", {31'd0, locked}, 32'd0);
    check("long line err_count", {24'd0, err_count}, 32'd1);
    check("long line frame_count", {16'd0, frame_count}, 32'd3);
    clean_frame();
    clean_frame();
    check("relock1 early", {31'd0, locked}, 32'd0);
    clean_frame();
    check("relock1 cycle", lock_rise_cyc, frame_pin_cyc + 2);
    check("relock1 frame_count", {16'd0, frame_count}, 32'd3);

    // One active line one pixel short while locked.
    te0 = te_cnt;
    pv0 = pv_cnt;
    drive_frame(TV_TOT, 10, 0, 1, -1);
    check("short act err pulses", te_cnt - te0, 32'd1);
    check("short act err cycle", te_rise_cyc, close_cyc + 2);
    check("short act locked", {31'd0, locked}, 32'd0);
    check("short act err_count", {24'd0, err_count}, 32'd2);
    check("short act pix after err", pv_since_te, 32'd0);
    check("short act pix count", pv_cnt - pv0, 32'd223);
    clean_frame();
    clean_frame();
    clean_frame();
    check("relock2", {31'd0, locked}, 32'd1);

    // Reset pulse mid-frame while locked.
    drive_frame(TV_TOT, -5, 0, 0, 15);
    check("midrst locked", {31'd0, snap_locked}, 32'd0);
    check("midrst pix_valid", {31'd0, snap_pv}, 32'd0);
    check("midrst frame_count", {16'd0, snap_fc}, 32'd0);
    check("midrst err_count", {24'd0, snap_ec}, 32'd0);
    clean_frame();
    clean_frame();
    check("midrst relock early", {31'd0, locked}, 32'd0);
    clean_frame();
    check("midrst relock cycle", lock_rise_cyc, frame_pin_cyc + 2);

    // Short frame while acquiring: silent drop back to hunting.
    drive_frame(TV_TOT, -5, 0, 0, 15);
    te0 = te_cnt;
    drive_frame(TV_TOT - 1, -5, 0, 0, -1);
    clean_frame();
    check("short frame locked", {31'd0, locked}, 32'd0);
    fc0 = te_cnt;
    clean_frame();
    clean_frame();
    clean_frame();
    check("short frame relock", {31'd0, locked}, 32'd1);
    check("short frame no err pulse", te_cnt - te0, 32'd0);
    check("short frame err_count", {24'd0, err_count}, 32'd0);
    check("short frame no err late", te_cnt - fc0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
